mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 47 ++++
 rtl/mdu_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: bundles the EX-stage request, the external multiplier bus
// and the HI/LO result port of the multiply/divide unit controller.
//
// Signal summary (directions given from the controller's side, modport slave):
//   start_i      in   EX stage holds a valid MDU instruction
//   op_i[2:0]    in   001 MULT, 010 MULTU, 011 DIV, 100 DIVU, others no-op
//   flush_i      in   EX flush / exception kill
//   rs_i, rt_i   in   operands (rs = dividend / multiplicand)
//   mul_p_i      in   64-bit product returned by the multiplier IP
//   mul_a_o/b_o  out  latched multiplier operands
//   mul_ce_o     out  multiplier clock enable
//   mul_signed_o out  multiplier signed-mode select
//   busy_o       out  EX stall request
//   done_o       out  one-cycle completion strobe
//   hilo_we_o    out  HI/LO write enable
//   hi_o, lo_o   out  result (HI = product[63:32] / remainder, LO = product[31:0] / quotient)
//
// The master modport is the pipeline side, which also returns the product.
interface mdu_ctrl_if;
    logic        start_i;
    logic [2:0]  op_i;
    logic        flush_i;
    logic [31:0] rs_i;
    logic [31:0] rt_i;
    logic [63:0] mul_p_i;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic        mul_ce_o;
    logic        mul_signed_o;
    logic        busy_o;
    logic        done_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start_i, op_i, flush_i, rs_i, rt_i, mul_p_i,
        input  mul_a_o, mul_b_o, mul_ce_o, mul_signed_o,
        input  busy_o, done_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, flush_i, rs_i, rt_i, mul_p_i,
        output mul_a_o, mul_b_o, mul_ce_o, mul_signed_o,
        output busy_o, done_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the EX stage.
//
// Multiplies are handed to an external pipelined multiplier of MUL_LAT
// cycles; divides run on a built-in radix-2 restoring divider (32 cycles).
// Results appear on hi_o/lo_o with a one-cycle done_o/hilo_we_o strobe.
//
// Parameters:
//   MUL_LAT  multiplier latency in cycles, 2..15 (default 13)
// Ports:
//   clk_i    clock, all state on the rising edge
//   rst_i    synchronous active-high reset
//   bus      mdu_ctrl_if.slave (request, multiplier bus, result)
// Configuration:
//   MDU_DIV_EN  when defined, builds the DIV state and divider datapath.
//               When undefined, DIV/DIVU complete one cycle after accept
//               with HI = LO = 0 and no divider hardware.
module mdu_ctrl #(
    parameter int MUL_LAT = 13
) (
    input logic       clk_i,
    input logic       rst_i,
    mdu_ctrl_if.slave bus
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
`ifdef MDU_DIV_EN
        ,
        DIV  = 2'd3
`endif
    } state_t;

    state_t      state;
    logic [3:0]  mul_cnt;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;
    // pend_* holds the result being presented in DONE; hi_q/lo_q hold the
    // last committed result. Commit happens only when DONE is not flushed,
    // so a killed operation never disturbs the architectural HI/LO.
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic is_mul;
    logic is_div;
    logic accept;

    assign is_mul = (bus.op_i == OP_MULT) || (bus.op_i == OP_MULTU);
    assign is_div = (bus.op_i == OP_DIV)  || (bus.op_i == OP_DIVU);
    // Flush beats start, and start is only looked at in IDLE.
    assign accept = (state == IDLE) && bus.start_i && !bus.flush_i && (is_mul || is_div);

`ifdef MDU_DIV_EN
    logic [4:0]  div_cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvsr_q;
    logic        neg_quo;
    logic        neg_rem;
    logic        div_signed;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    assign div_signed = (bus.op_i == OP_DIV);
    assign abs_rs     = (div_signed && bus.rs_i[31]) ? (32'd0 - bus.rs_i) : bus.rs_i;
    assign abs_rt     = (div_signed && bus.rt_i[31]) ? (32'd0 - bus.rt_i) : bus.rt_i;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, keep the trial difference only if it did not go negative.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvsr_q};
        rem_nx  = shifted[31:0];
        quo_nx  = {quo_q[30:0], 1'b0};
        if (!diff[32]) begin
            rem_nx = diff[31:0];
            quo_nx = {quo_q[30:0], 1'b1};
        end
    end
`endif

    // Controller FSM plus operand/result registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mul_cnt    <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
            pend_hi    <= '0;
            pend_lo    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MDU_DIV_EN
            div_cnt    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            neg_quo    <= 1'b0;
            neg_rem    <= 1'b0;
`endif
        end else if (bus.flush_i) begin
            state   <= IDLE;
            mul_cnt <= '0;
`ifdef MDU_DIV_EN
            div_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            mul_a      <= bus.rs_i;
                            mul_b      <= bus.rt_i;
                            mul_signed <= (bus.op_i == OP_MULT);
                            mul_cnt    <= '0;
                            state      <= MUL;
                        end else begin
`ifdef MDU_DIV_EN
                            if (bus.rt_i == 32'd0) begin
                                pend_hi <= bus.rs_i;
                                pend_lo <= '1;
                                state   <= DONE;
                            end else begin
                                rem_q   <= '0;
                                quo_q   <= abs_rs;
                                dvsr_q  <= abs_rt;
                                neg_quo <= div_signed && (bus.rs_i[31] ^ bus.rt_i[31]);
                                neg_rem <= div_signed && bus.rs_i[31];
                                div_cnt <= '0;
                                state   <= DIV;
                            end
`else
                            pend_hi <= '0;
                            pend_lo <= '0;
                            state   <= DONE;
`endif
                        end
                    end
                end
                MUL: begin
                    if (mul_cnt == MUL_LAST) begin
                        pend_hi <= bus.mul_p_i[63:32];
                        pend_lo <= bus.mul_p_i[31:0];
                        mul_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        mul_cnt <= mul_cnt + 4'd1;
                    end
                end
`ifdef MDU_DIV_EN
                DIV: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (div_cnt == 5'd31) begin
                        // Sign fix-up on the final step's values.
                        pend_lo <= neg_quo ? (32'd0 - quo_nx) : quo_nx;
                        pend_hi <= neg_rem ? (32'd0 - rem_nx) : rem_nx;
                        div_cnt <= '0;
                        state   <= DONE;
                    end else begin
                        div_cnt <= div_cnt + 5'd1;
                    end
                end
`endif
                DONE: begin
                    hi_q  <= pend_hi;
                    lo_q  <= pend_lo;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mul_a_o      = mul_a;
    assign bus.mul_b_o      = mul_b;
    assign bus.mul_signed_o = mul_signed;
    assign bus.mul_ce_o     = (state == MUL) && !bus.flush_i;
    assign bus.done_o       = (state == DONE) && !bus.flush_i;
    assign bus.hilo_we_o    = (state == DONE) && !bus.flush_i;
    assign bus.hi_o         = (state == DONE) ? pend_hi : hi_q;
    assign bus.lo_o         = (state == DONE) ? pend_lo : lo_q;
`ifdef MDU_DIV_EN
    assign bus.busy_o       = accept || (state == MUL) || (state == DIV);
`else
    assign bus.busy_o       = accept || (state == MUL);
`endif

endmodule
